// File: rtl/led_status_ctrl_pkg.sv
// Shared types and constants for the port status LED controller.
// Mode and state encodings are common to the top level, channels and bench.
package led_status_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_OFF    = 2'b01,
        MODE_ON     = 2'b10,
        MODE_LOCATE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_DOWN = 2'b00,
        S_UP   = 2'b01,
        S_ACT  = 2'b10
    } state_e;

    // Blink ticks per half-period of the locate pattern.
    localparam int LOCATE_TICKS = 4;

    // Stretch counter must hold STRETCH_CYC itself without wrapping.
    function automatic int stretch_cnt_width(input int stretch_cyc);
        return $clog2(stretch_cyc + 1);
    endfunction

endpackage

// File: rtl/led_status_ctrl_if.sv
// Status-bus / LED-pin bundle between the MAC/PHY side and the LED controller.
// master = status source (drives link/act/mode/lamp test), slave = controller.
interface led_status_ctrl_if #(
    parameter int NUM_CH = 8
);
    logic [NUM_CH-1:0]   link_i;
    logic [NUM_CH-1:0]   act_i;
    logic [2*NUM_CH-1:0] mode_i;
    logic                lamp_test_i;
    logic [NUM_CH-1:0]   led_o;
    logic [NUM_CH-1:0]   link_up_o;

    modport master (
        output link_i,
        output act_i,
        output mode_i,
        output lamp_test_i,
        input  led_o,
        input  link_up_o
    );

    modport slave (
        input  link_i,
        input  act_i,
        input  mode_i,
        input  lamp_test_i,
        output led_o,
        output link_up_o
    );
endinterface

// File: rtl/led_status_ctrl_chan.sv
// One LED channel: link/activity FSM with activity stretch counter and the
// override/lamp-test output mux driving a registered pin.
module led_status_chan
    import led_status_pkg::*;
#(
    parameter int STRETCH_CYC = 65536,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_link,
    input  logic       i_act,
    input  logic [1:0] i_mode,
    input  logic       i_lamp_test,
    input  logic       i_fast_phase,
    input  logic       i_slow_phase,
    output logic       o_led,
    output logic       o_link_up
);

    localparam int             CNT_W    = stretch_cnt_width(STRETCH_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic           PIN_XOR  = (ACTIVE_LOW != 0);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_led;
    logic             r_link_up;
    logic             w_auto_lit;
    logic             w_lit;

    always_comb begin
        w_auto_lit = 1'b0;
        case (r_state)
            S_UP:    w_auto_lit = 1'b1;
            S_ACT:   w_auto_lit = i_fast_phase;
            default: w_auto_lit = 1'b0;
        endcase
    end

    always_comb begin
        w_lit = 1'b0;
        if (i_lamp_test) begin
            w_lit = 1'b1;
        end else begin
            case (mode_e'(i_mode))
                MODE_OFF:    w_lit = 1'b0;
                MODE_ON:     w_lit = 1'b1;
                MODE_LOCATE: w_lit = i_slow_phase;
                default:     w_lit = w_auto_lit;
            endcase
        end
    end

    // The FSM runs regardless of mode so AUTO always reflects live status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_DOWN;
            r_cnt     <= '0;
            r_led     <= PIN_XOR;
            r_link_up <= 1'b0;
        end else begin
            r_led <= w_lit ^ PIN_XOR;
            if (!i_link) begin
                r_state   <= S_DOWN;
                r_cnt     <= '0;
                r_link_up <= 1'b0;
            end else begin
                // Every transition out of a linked cycle lands in S_UP or S_ACT.
                r_link_up <= 1'b1;
                case (r_state)
                    S_DOWN: begin
                        r_state <= S_UP;
                        r_cnt   <= '0;
                    end
                    S_UP: begin
                        if (i_act) begin
                            r_state <= S_ACT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                    S_ACT: begin
                        if (i_act) begin
                            r_cnt <= CNT_LOAD;
                        end else if (r_cnt == CNT_ONE) begin
                            r_state <= S_UP;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_DOWN;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_led     = r_led;
    assign o_link_up = r_link_up;

endmodule

// File: rtl/led_status_ctrl.sv
// N-channel port status LED controller: shared blink timebase plus one
// led_status_chan per port.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int BLINK_DIV   = 4096,
    parameter int STRETCH_CYC = 65536,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    led_status_ctrl_if.slave  bus
);

    localparam int               DIV_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
    localparam int               TC_W     = $clog2(LOCATE_TICKS);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(LOCATE_TICKS - 1);

    logic [DIV_W-1:0]  r_div;
    logic [TC_W-1:0]   r_tick_cnt;
    logic              r_fast_phase;
    logic              r_slow_phase;
    logic              w_tick;
    logic [NUM_CH-1:0] w_led;
    logic [NUM_CH-1:0] w_link_up;

    assign w_tick = (r_div == DIV_LAST);

    // fast_phase flips every tick; slow_phase every LOCATE_TICKS ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_tick_cnt   <= '0;
            r_fast_phase <= 1'b0;
            r_slow_phase <= 1'b0;
        end else if (w_tick) begin
            r_div        <= '0;
            r_fast_phase <= ~r_fast_phase;
            if (r_tick_cnt == TC_LAST) begin
                r_tick_cnt   <= '0;
                r_slow_phase <= ~r_slow_phase;
            end else begin
                r_tick_cnt <= r_tick_cnt + TC_W'(1);
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
            led_status_chan #(
                .STRETCH_CYC (STRETCH_CYC),
                .ACTIVE_LOW  (ACTIVE_LOW)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .i_link       (bus.link_i[gi]),
                .i_act        (bus.act_i[gi]),
                .i_mode       (bus.mode_i[2*gi +: 2]),
                .i_lamp_test  (bus.lamp_test_i),
                .i_fast_phase (r_fast_phase),
                .i_slow_phase (r_slow_phase),
                .o_led        (w_led[gi]),
                .o_link_up    (w_link_up[gi])
            );
        end
    endgenerate

    assign bus.led_o     = w_led;
    assign bus.link_up_o = w_link_up;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl (4 channels, BLINK_DIV=4, STRETCH_CYC=10,
// active-low pins); one line per failing check plus a summary line.
module tb_led_status_ctrl;
    import led_status_pkg::*;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    led_status_ctrl_if #(.NUM_CH(NCH)) bus ();

    led_status_ctrl #(
        .NUM_CH      (NCH),
        .BLINK_DIV   (4),
        .STRETCH_CYC (10),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock edges since the last reset edge; phases derive from it.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Pin value for a lit=fast_phase channel, as registered on edge c.
    function automatic logic fast_pin(input int c);
        logic ph;
        ph = (((c - 1) / 4) % 2) != 0;
        return !ph;
    endfunction

    function automatic logic slow_pin(input int c);
        logic ph;
        ph = (((c - 1) / 16) % 2) != 0;
        return !ph;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%b expected=%b (cyc %0d)", tag, obs, exp, cyc);
    endtask

    initial begin
        rst             = 1'b1;
        bus.link_i      = 4'hF;
        bus.act_i       = 4'hF;
        bus.mode_i      = 8'h00;
        bus.lamp_test_i = 1'b0;

        // Reset holds pins off and link_up low even with link/act asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_led", 8'(bus.led_o), 8'hF);
            chk("rst_link_up", 8'(bus.link_up_o), 8'h0);
        end
        rst        = 1'b0;
        bus.act_i  = 4'h0;
        step();
        chk("post_rst_link_up", 8'(bus.link_up_o), 8'hF);
        chk("post_rst_led", 8'(bus.led_o), 8'hF);
        step();
        chk("post_rst_led_up", 8'(bus.led_o), 8'h0);

        bus.link_i = 4'h0;
        step(2);
        chk("all_down_led", 8'(bus.led_o), 8'hF);
        chk("all_down_link_up", 8'(bus.link_up_o), 8'h0);

        // Link up on channel 0.
        bus.link_i = 4'h1;
        step();
        chk("linkup_t1_up", 8'(bus.link_up_o), 8'h1);
        chk("linkup_t1_led", 8'(bus.led_o), 8'hF);
        step();
        chk("linkup_t2_led", 8'(bus.led_o), 8'hE);
        step(3);
        chk("linkup_steady", 8'(bus.led_o), 8'hE);

        // Single activity pulse: blink for edges 2..11, solid from 12.
        bus.act_i = 4'h1;
        step();
        bus.act_i = 4'h0;
        chk("stretch_k1", 8'(bus.led_o), 8'hE);
        for (int k = 2; k <= 11; k++) begin
            step();
            chk("stretch_blink", 8'({3'b111, fast_pin(cyc)}), 8'(bus.led_o));
        end
        step();
        chk("stretch_end", 8'(bus.led_o), 8'hE);
        step(3);
        chk("stretch_after", 8'(bus.led_o), 8'hE);

        // Pulses every 5 cycles keep the channel blinking without a gap.
        for (int k = 0; k < 20; k++) begin
            bus.act_i = (k % 5 == 0) ? 4'h1 : 4'h0;
            step();
            if (k >= 1) chk("retrigger_blink", 8'(bus.led_o), 8'({3'b111, fast_pin(cyc)}));
        end
        bus.act_i = 4'h0;
        step(12);
        chk("retrigger_end", 8'(bus.led_o), 8'hE);

        // Link drop during activity.
        bus.act_i = 4'h1;
        step();
        bus.act_i = 4'h0;
        step(2);
        bus.link_i = 4'h0;
        step();
        chk("drop_link_up", 8'(bus.link_up_o), 8'h0);
        step();
        chk("drop_led", 8'(bus.led_o), 8'hF);
        bus.link_i = 4'h1;
        step();
        chk("relink_up", 8'(bus.link_up_o), 8'h1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("relink_no_blink", 8'(bus.led_o), 8'hE);
        end

        // Link and act rising together: act ignored, no blink.
        bus.link_i = 4'h0;
        step(2);
        chk("simul_down", 8'(bus.led_o), 8'hF);
        bus.link_i = 4'h1;
        bus.act_i  = 4'h1;
        step();
        bus.act_i  = 4'h0;
        chk("simul_link_up", 8'(bus.link_up_o), 8'h1);
        for (int k = 2; k <= 11; k++) begin
            step();
            chk("simul_no_blink", 8'(bus.led_o), 8'hE);
        end

        // Modes {LOCATE, ON, OFF, AUTO} with continuous activity everywhere.
        bus.link_i = 4'hF;
        bus.act_i  = 4'hF;
        bus.mode_i = {MODE_LOCATE, MODE_ON, MODE_OFF, MODE_AUTO};
        step(3);
        for (int k = 0; k < 32; k++) begin
            step();
            chk("modes", 8'(bus.led_o), 8'({slow_pin(cyc), 1'b0, 1'b1, fast_pin(cyc)}));
        end
        bus.lamp_test_i = 1'b1;
        step();
        chk("lamp_test", 8'(bus.led_o), 8'h0);
        bus.lamp_test_i = 1'b0;
        step();
        chk("lamp_test_off", 8'(bus.led_o), 8'({slow_pin(cyc), 1'b0, 1'b1, fast_pin(cyc)}));

        // Return ch1 from OFF to AUTO after activity has expired.
        bus.act_i = 4'h0;
        step(12);
        chk("pre_return", 8'(bus.led_o), 8'({slow_pin(cyc), 1'b0, 1'b1, 1'b0}));
        bus.mode_i = {MODE_LOCATE, MODE_ON, MODE_AUTO, MODE_AUTO};
        step();
        chk("mode_return", 8'(bus.led_o), 8'({slow_pin(cyc), 1'b0, 1'b0, 1'b0}));

        // Reset in the middle of activity leaves no stretch state behind.
        bus.mode_i = 8'h00;
        bus.act_i  = 4'hF;
        step(2);
        rst       = 1'b1;
        bus.act_i = 4'h0;
        step();
        chk("midrst_led", 8'(bus.led_o), 8'hF);
        chk("midrst_link_up", 8'(bus.link_up_o), 8'h0);
        rst = 1'b0;
        step();
        chk("midrst_relink", 8'(bus.link_up_o), 8'hF);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("midrst_no_blink", 8'(bus.led_o), 8'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
